// File: rtl/div_seq_if.sv
// Start/done handshake bundle for the sequential divider div_seq.
// The master drives the operands, and the slave returns the results and flags.
interface div_seq_if #(
  parameter int m = 12
) ();
  logic           start;
  logic [2*m-1:0] dividend;
  logic [m-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [m-1:0]   quotient;
  logic [m-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/div_seq.sv
// Restoring divider: 2m-bit dividend / m-bit divisor, one quotient bit per clock.
// Optional macro DIV_ROUND_EN adds a ROUND state (round-half-up, saturating quotient).
module div_seq #(
  parameter int m = 12
) (
  input logic     clk,
  input logic     rst_n,
  div_seq_if.slave bus
);

  localparam int CNT_W = $clog2(m);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
`ifdef DIV_ROUND_EN
    ROUND = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             done_d, busy_d;

  logic [m-1:0]     rem_p0, quo_p0, shf_p0, dsr_p0;
  logic             dz_p0, ov_p0;

  logic [m-1:0]     hi;
  logic             dz_in, ov_in;
  logic [m:0]       r_shift, r_sub;
  logic             r_ge;

  function automatic logic [m-1:0] sat_inc(input logic [m-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

`ifdef DIV_ROUND_EN
  function automatic logic round_up(input logic [m-1:0] r, input logic [m-1:0] d);
    return {r, 1'b0} >= {1'b0, d};
  endfunction
`endif

  assign hi      = bus.dividend[2*m-1:m];
  assign dz_in   = (bus.divisor == '0);
  assign ov_in   = dz_in || (hi >= bus.divisor);
  assign last    = (cnt == CNT_W'(m - 1));
  assign r_shift = {rem_p0, shf_p0[m-1]};
  assign r_ge    = (r_shift >= {1'b0, dsr_p0});
  assign r_sub   = r_shift - {1'b0, dsr_p0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == RUN) cnt <= cnt + 1'b1;
      else              cnt <= '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.start) state_next = ov_in ? DONE : RUN;
`ifdef DIV_ROUND_EN
      RUN:   if (last) state_next = ROUND;
      ROUND: state_next = DONE;
`else
      RUN:   if (last) state_next = DONE;
`endif
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy also covers the done cycle, which is already back in IDLE
  always_comb begin
    done_d = (state == DONE);
    busy_d = (state == DONE) || (state_next != IDLE);
  end

  // Stage p0: operand capture and one restoring step per RUN cycle
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (bus.start) begin
        dsr_p0 <= bus.divisor;
        shf_p0 <= bus.dividend[m-1:0];
        dz_p0  <= dz_in;
        ov_p0  <= ov_in;
        if (ov_in) begin
          quo_p0 <= '1;
          rem_p0 <= '0;
        end else begin
          rem_p0 <= hi;
        end
      end
      RUN: begin
        shf_p0 <= {shf_p0[m-2:0], 1'b0};
        quo_p0 <= {quo_p0[m-2:0], r_ge};
        rem_p0 <= r_ge ? r_sub[m-1:0] : r_shift[m-1:0];
      end
`ifdef DIV_ROUND_EN
      ROUND: if (round_up(rem_p0, dsr_p0)) quo_p0 <= sat_inc(quo_p0);
`endif
      default: ;
    endcase
  end

  // Stage p1: registered results, held until the next DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      bus.busy <= busy_d;
      bus.done <= done_d;
      if (state == DONE) begin
        bus.quotient    <= quo_p0;
        bus.remainder   <= rem_p0;
        bus.div_by_zero <= dz_p0;
        bus.overflow    <= ov_p0;
      end
    end
  end

endmodule
